// File: rtl/ahb3lite_arb2.sv
// Two-master to one-slave AHB3-lite arbiter with per-master address holding.
// Round-robin grant with optional burst lock; uncontested requests pass through.
module ahb3lite_arb2 #(
  parameter bit BURST_LOCK = 1'b1
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [1:0]       M_HSEL,
  input  logic [1:0][31:0] M_HADDR,
  input  logic [1:0][31:0] M_HWDATA,
  input  logic [1:0]       M_HWRITE,
  input  logic [1:0][2:0]  M_HSIZE,
  input  logic [1:0][2:0]  M_HBURST,
  input  logic [1:0][3:0]  M_HPROT,
  input  logic [1:0][1:0]  M_HTRANS,
  output logic [1:0][31:0] M_HRDATA,
  output logic [1:0]       M_HREADYOUT,
  output logic [1:0]       M_HRESP,
  output logic             S_HSEL,
  output logic [31:0]      S_HADDR,
  output logic [31:0]      S_HWDATA,
  output logic             S_HWRITE,
  output logic [2:0]       S_HSIZE,
  output logic [2:0]       S_HBURST,
  output logic [3:0]       S_HPROT,
  output logic [1:0]       S_HTRANS,
  output logic             S_HREADY,
  input  logic [31:0]      S_HRDATA,
  input  logic             S_HREADYOUT,
  input  logic             S_HRESP,
  output logic             HMASTER
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA
  } st_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [1:0]  trans;
  } aph_t;

  st_e  [1:0] st_q, st_d;
  aph_t [1:0] pend_q, pend_d;
  logic [1:0] pend_vld_q, pend_vld_d;
  aph_t       hold_q, hold_d;
  logic       last_q, last_d;
  logic       hmaster_q, hmaster_d;

  aph_t [1:0] live, cfld;
  logic [1:0] rdy, resp, req, cand, granted;
  logic       lock, issue, win;
  aph_t       sel;

  always_comb begin
    live       = '0;
    cfld       = '0;
    rdy        = '0;
    resp       = '0;
    req        = '0;
    cand       = '0;
    granted    = '0;
    lock       = 1'b0;
    issue      = 1'b0;
    win        = 1'b0;
    sel        = hold_q;
    st_d       = st_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    hold_d     = hold_q;
    last_d     = last_q;
    hmaster_d  = hmaster_q;

    for (int m = 0; m < 2; m++) begin
      live[m] = '{addr:  M_HADDR[m],
                  write: M_HWRITE[m],
                  size:  M_HSIZE[m],
                  burst: M_HBURST[m],
                  prot:  M_HPROT[m],
                  trans: M_HTRANS[m]};
      unique case (st_q[m])
        ST_WAIT: rdy[m] = 1'b0;
        ST_DATA: rdy[m] = S_HREADYOUT;
        default: rdy[m] = 1'b1;
      endcase
      resp[m] = (st_q[m] == ST_DATA) && S_HRESP;
      req[m]  = M_HSEL[m] && M_HTRANS[m][1] && rdy[m];
      cand[m] = pend_vld_q[m] || req[m];
      cfld[m] = pend_vld_q[m] ? pend_q[m] : live[m];
      // a stored SEQ cannot continue a burst the other master interrupted
      if (pend_vld_q[m] && (pend_q[m].trans == TR_SEQ) &&
          (last_q != 1'(m)))
        cfld[m].trans = TR_NONSEQ;
    end

    lock  = BURST_LOCK && req[last_q] &&
            (M_HTRANS[last_q] == TR_SEQ);
    issue = S_HREADYOUT && (|cand);

    unique case (1'b1)
      lock:                             win = last_q;
      (!lock && cand[0] && cand[1]):    win = !last_q;
      default:                          win = cand[1];
    endcase

    if (issue) begin
      sel       = cfld[win];
      hold_d    = cfld[win];
      last_d    = win;
      hmaster_d = win;
    end

    for (int m = 0; m < 2; m++) begin
      granted[m] = issue && (win == 1'(m));
      if (granted[m]) begin
        pend_vld_d[m] = 1'b0;
        st_d[m]       = ST_DATA;
      end else if (req[m]) begin
        pend_vld_d[m] = 1'b1;
        pend_d[m]     = live[m];
        st_d[m]       = ST_WAIT;
      end else if (st_q[m] == ST_DATA && S_HREADYOUT) begin
        st_d[m]       = ST_IDLE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int m = 0; m < 2; m++) st_q[m] <= ST_IDLE;
      pend_q     <= '0;
      pend_vld_q <= '0;
      hold_q     <= '0;
      last_q     <= 1'b1;
      hmaster_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      hold_q     <= hold_d;
      last_q     <= last_d;
      hmaster_q  <= hmaster_d;
    end
  end

  assign M_HRDATA    = {S_HRDATA, S_HRDATA};
  assign M_HREADYOUT = rdy;
  assign M_HRESP     = resp;
  assign S_HSEL      = issue;
  assign S_HTRANS    = issue ? sel.trans : TR_IDLE;
  assign S_HADDR     = sel.addr;
  assign S_HWRITE    = sel.write;
  assign S_HSIZE     = sel.size;
  assign S_HBURST    = sel.burst;
  assign S_HPROT     = sel.prot;
  assign S_HWDATA    = M_HWDATA[hmaster_q];
  assign S_HREADY    = S_HREADYOUT;
  assign HMASTER     = hmaster_q;

endmodule
